// File: rtl/multi_dataflow_package.sv
// Shared types and default widths for the multi-dataflow streamer sink responder.
package multi_dataflow_package;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_CNT_W  = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } sink_resp_state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] base_addr;
      logic [DEF_CNT_W-1:0]  trans_size;
      logic [DEF_CNT_W-1:0]  line_length;
      logic [DEF_ADDR_W-1:0] line_stride;
      logic [DEF_ADDR_W-1:0] step;
   } sink_resp_job_t;

endpackage

// File: rtl/multi_dataflow_sink_addrgen.sv
// Job registers plus word/line counters producing the 2-level TCDM write address.
module multi_dataflow_sink_addrgen #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              i_load,
   input  logic              i_advance,
   input  logic              i_clear,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [CNT_W-1:0]  i_trans_size,
   input  logic [CNT_W-1:0]  i_line_length,
   input  logic [ADDR_W-1:0] i_line_stride,
   input  logic [ADDR_W-1:0] i_step,
   output logic [ADDR_W-1:0] o_addr,
   output logic [CNT_W-1:0]  o_cnt,
   output logic              o_last
);

   logic [CNT_W-1:0]  r_trans_size;
   logic [CNT_W-1:0]  r_line_len;
   logic [ADDR_W-1:0] r_line_stride;
   logic [ADDR_W-1:0] r_step;
   logic [ADDR_W-1:0] r_line_base;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_word_cnt;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_line_end;

   assign w_line_end = (r_word_cnt == r_line_len - CNT_W'(1));

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_trans_size  <= '0;
         r_line_len    <= '0;
         r_line_stride <= '0;
         r_step        <= '0;
         r_line_base   <= '0;
         r_addr        <= '0;
         r_word_cnt    <= '0;
         r_cnt         <= '0;
      end else if (i_clear) begin
         r_line_base <= '0;
         r_addr      <= '0;
         r_word_cnt  <= '0;
         r_cnt       <= '0;
      end else if (i_load) begin
         r_trans_size  <= i_trans_size;
         // A zero line length means the whole transfer is one line.
         r_line_len    <= (i_line_length == '0) ? i_trans_size : i_line_length;
         r_line_stride <= i_line_stride;
         r_step        <= i_step;
         r_line_base   <= i_base_addr;
         r_addr        <= i_base_addr;
         r_word_cnt    <= '0;
         r_cnt         <= '0;
      end else if (i_advance) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_line_end) begin
            r_line_base <= r_line_base + r_line_stride;
            r_addr      <= r_line_base + r_line_stride;
            r_word_cnt  <= '0;
         end else begin
            r_addr     <= r_addr + r_step;
            r_word_cnt <= r_word_cnt + CNT_W'(1);
         end
      end
   end

   assign o_addr = r_addr;
   assign o_cnt  = r_cnt;
   assign o_last = (r_cnt == r_trans_size - CNT_W'(1));

endmodule

// File: rtl/multi_dataflow_sink_responder.sv
// Streamer sink responder: accepts a job from the controller FSM and drains the
// engine stream into TCDM word writes along the address-generator pattern.
module multi_dataflow_sink_responder
   import multi_dataflow_package::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                req_start_i,
   input  logic [ADDR_W-1:0]   base_addr_i,
   input  logic [CNT_W-1:0]    trans_size_i,
   input  logic [CNT_W-1:0]    line_length_i,
   input  logic [ADDR_W-1:0]   line_stride_i,
   input  logic [ADDR_W-1:0]   step_i,
   output logic                ready_start_o,
   output logic                done_o,
   output logic [CNT_W-1:0]    cnt_o,
   input  logic [DATA_W-1:0]   stream_data_i,
   input  logic [DATA_W/8-1:0] stream_strb_i,
   input  logic                stream_valid_i,
   output logic                stream_ready_o,
   output logic                tcdm_req_o,
   input  logic                tcdm_gnt_i,
   output logic [ADDR_W-1:0]   tcdm_add_o,
   output logic                tcdm_wen_o,
   output logic [DATA_W/8-1:0] tcdm_be_o,
   output logic [DATA_W-1:0]   tcdm_data_o
);

   sink_resp_state_t r_state;
   logic             r_done;
   logic             w_run;
   logic             w_beat;
   logic             w_load;
   logic             w_advance;
   logic             w_last;

   assign w_run     = (r_state == ST_RUN);
   assign w_beat    = w_run & stream_valid_i & tcdm_gnt_i;
   // A beat during clear still happens on the bus but is not counted.
   assign w_load    = ~w_run & req_start_i & ~clear_i;
   assign w_advance = w_beat & ~clear_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else if (clear_i) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= req_start_i && (trans_size_i == '0);
               if (req_start_i && (trans_size_i != '0)) r_state <= ST_RUN;
            end
            ST_RUN: begin
               r_done <= w_beat & w_last;
               if (w_beat && w_last) r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   multi_dataflow_sink_addrgen #(
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
   ) u_addrgen (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .i_load       (w_load),
      .i_advance    (w_advance),
      .i_clear      (clear_i),
      .i_base_addr  (base_addr_i),
      .i_trans_size (trans_size_i),
      .i_line_length(line_length_i),
      .i_line_stride(line_stride_i),
      .i_step       (step_i),
      .o_addr       (tcdm_add_o),
      .o_cnt        (cnt_o),
      .o_last       (w_last)
   );

   assign ready_start_o  = ~w_run;
   assign done_o         = r_done;
   assign tcdm_req_o     = w_run & stream_valid_i;
   assign stream_ready_o = w_run & tcdm_gnt_i;
   assign tcdm_wen_o     = 1'b0;
   assign tcdm_be_o      = stream_strb_i;
   assign tcdm_data_o    = stream_data_i;

endmodule

// File: tb/tb_multi_dataflow_sink_responder.sv
// Scoreboard bench for the sink responder: expected writes are queued when data is presented.
module tb_multi_dataflow_sink_responder;
   import multi_dataflow_package::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        clear_i;
   logic        req_start_i;
   logic [31:0] base_addr_i;
   logic [31:0] trans_size_i;
   logic [31:0] line_length_i;
   logic [31:0] line_stride_i;
   logic [31:0] step_i;
   logic        ready_start_o;
   logic        done_o;
   logic [31:0] cnt_o;
   logic [31:0] stream_data_i;
   logic [3:0]  stream_strb_i;
   logic        stream_valid_i;
   logic        stream_ready_o;
   logic        tcdm_req_o;
   logic        tcdm_gnt_i;
   logic [31:0] tcdm_add_o;
   logic        tcdm_wen_o;
   logic [3:0]  tcdm_be_o;
   logic [31:0] tcdm_data_o;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } beat_t;

   beat_t          sb[$];
   sink_resp_job_t cur_job;
   int             checks = 0;
   int             errors = 0;

   multi_dataflow_sink_responder dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .req_start_i   (req_start_i),
      .base_addr_i   (base_addr_i),
      .trans_size_i  (trans_size_i),
      .line_length_i (line_length_i),
      .line_stride_i (line_stride_i),
      .step_i        (step_i),
      .ready_start_o (ready_start_o),
      .done_o        (done_o),
      .cnt_o         (cnt_o),
      .stream_data_i (stream_data_i),
      .stream_strb_i (stream_strb_i),
      .stream_valid_i(stream_valid_i),
      .stream_ready_o(stream_ready_o),
      .tcdm_req_o    (tcdm_req_o),
      .tcdm_gnt_i    (tcdm_gnt_i),
      .tcdm_add_o    (tcdm_add_o),
      .tcdm_wen_o    (tcdm_wen_o),
      .tcdm_be_o     (tcdm_be_o),
      .tcdm_data_o   (tcdm_data_o)
   );

   always #5 clk_i = ~clk_i;

   // Word k of a job sits at base + line*stride + word*step.
   function automatic logic [31:0] exp_addr(input sink_resp_job_t j, input int k);
      int ll;
      ll = (j.line_length == 0) ? int'(j.trans_size) : int'(j.line_length);
      return j.base_addr + 32'(k / ll) * j.line_stride + 32'(k % ll) * j.step;
   endfunction

   function automatic sink_resp_job_t mk_job(input logic [31:0] b, input logic [31:0] t,
                                             input logic [31:0] l, input logic [31:0] s,
                                             input logic [31:0] st);
      sink_resp_job_t j;
      j.base_addr   = b;
      j.trans_size  = t;
      j.line_length = l;
      j.line_stride = s;
      j.step        = st;
      return j;
   endfunction

   // Every completed bus beat must match the oldest queued expectation.
   always @(negedge clk_i) begin
      if (rst_ni && tcdm_req_o && tcdm_gnt_i) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat addr=%h data=%h (no write expected)", tcdm_add_o, tcdm_data_o);
         end else begin
            beat_t e;
            e = sb.pop_front();
            if (tcdm_add_o !== e.addr || tcdm_data_o !== e.data || tcdm_be_o !== e.be) begin
               errors++;
               $display("FAIL beat got addr=%h data=%h be=%h expected addr=%h data=%h be=%h",
                        tcdm_add_o, tcdm_data_o, tcdm_be_o, e.addr, e.data, e.be);
            end
         end
      end
   end

   task automatic step_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_job(input sink_resp_job_t j);
      cur_job       = j;
      base_addr_i   = j.base_addr;
      trans_size_i  = j.trans_size;
      line_length_i = j.line_length;
      line_stride_i = j.line_stride;
      step_i        = j.step;
      req_start_i   = 1'b1;
      step_cycle();
      req_start_i   = 1'b0;
      base_addr_i   = $urandom;
      trans_size_i  = $urandom_range(1, 50);
      line_length_i = $urandom_range(1, 7);
      line_stride_i = $urandom;
      step_i        = $urandom;
   endtask

   // Presents words first..first+count-1 of cur_job under random valid/grant.
   task automatic drive_job(input int first, input int count, input int gnt_pct,
                            input int valid_pct, output int cycles);
      int  k;
      bit  pres;
      k      = first;
      pres   = 1'b0;
      cycles = 0;
      while (k < first + count && cycles < 2000) begin
         if (!pres) begin
            if ($urandom_range(99) < valid_pct) begin
               stream_data_i  = $urandom;
               stream_strb_i  = 4'($urandom);
               stream_valid_i = 1'b1;
               pres           = 1'b1;
               sb.push_back('{addr: exp_addr(cur_job, k), data: stream_data_i, be: stream_strb_i});
            end else begin
               stream_valid_i = 1'b0;
            end
         end
         tcdm_gnt_i = ($urandom_range(99) < gnt_pct);
         @(negedge clk_i);
         checks++;
         if (ready_start_o !== 1'b0 || stream_ready_o !== tcdm_gnt_i ||
             tcdm_req_o !== stream_valid_i || tcdm_wen_o !== 1'b0) begin
            errors++;
            $display("FAIL run_glue got rdy_start=%b s_ready=%b req=%b wen=%b expected 0 %b %b 0",
                     ready_start_o, stream_ready_o, tcdm_req_o, tcdm_wen_o, tcdm_gnt_i, stream_valid_i);
         end
         if (stream_valid_i && tcdm_gnt_i) begin
            k++;
            pres = 1'b0;
         end
         step_cycle();
         cycles++;
      end
      stream_valid_i = 1'b0;
      tcdm_gnt_i     = 1'b0;
      checks++;
      if (k < first + count) begin
         errors++;
         $display("FAIL drive_timeout got %0d beats expected %0d", k - first, count);
      end
   endtask

   task automatic check_done(input string name, input logic [31:0] n);
      checks++;
      if (done_o !== 1'b1 || ready_start_o !== 1'b1 || cnt_o !== n) begin
         errors++;
         $display("FAIL %s_done got done=%b rdy=%b cnt=%0d expected 1 1 %0d",
                  name, done_o, ready_start_o, cnt_o, n);
      end
      step_cycle();
      checks++;
      if (done_o !== 1'b0 || cnt_o !== n) begin
         errors++;
         $display("FAIL %s_after got done=%b cnt=%0d expected 0 %0d", name, done_o, cnt_o, n);
      end
   endtask

   task automatic test_reset();
      stream_valid_i = 1'b1;
      tcdm_gnt_i     = 1'b1;
      #1;
      checks++;
      if (ready_start_o !== 1'b1 || done_o !== 1'b0 || cnt_o !== 32'd0 || stream_ready_o !== 1'b0 ||
          tcdm_req_o !== 1'b0 || tcdm_add_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_values got rdy=%b done=%b cnt=%0d srdy=%b req=%b add=%h expected 1 0 0 0 0 0",
                  ready_start_o, done_o, cnt_o, stream_ready_o, tcdm_req_o, tcdm_add_o);
      end
      step_cycle();
      rst_ni         = 1'b1;
      stream_valid_i = 1'b0;
      tcdm_gnt_i     = 1'b0;
      step_cycle();
   endtask

   task automatic test_single_line();
      int cyc;
      start_job(mk_job(32'h1000, 4, 0, 32'h0, 4));
      drive_job(0, 4, 100, 100, cyc);
      checks++;
      if (cyc !== 4) begin
         errors++;
         $display("FAIL single_cycles got %0d expected 4", cyc);
      end
      check_done("single", 4);
   endtask

   task automatic test_2d();
      int cyc;
      start_job(mk_job(32'h2000, 6, 3, 32'h40, 4));
      drive_job(0, 6, 100, 100, cyc);
      check_done("twod", 6);
   endtask

   task automatic test_random();
      int cyc;
      start_job(mk_job(32'hFFFF_FFE0, 16, 5, 32'h100, 8));
      drive_job(0, 16, 50, 70, cyc);
      check_done("random", 16);
   endtask

   task automatic test_zero_len();
      stream_valid_i = 1'b1;
      tcdm_gnt_i     = 1'b1;
      start_job(mk_job(32'h5000, 0, 0, 32'h0, 4));
      checks++;
      if (done_o !== 1'b1 || ready_start_o !== 1'b1 || tcdm_req_o !== 1'b0 ||
          stream_ready_o !== 1'b0 || cnt_o !== 32'd0) begin
         errors++;
         $display("FAIL zero_len got done=%b rdy=%b req=%b srdy=%b cnt=%0d expected 1 1 0 0 0",
                  done_o, ready_start_o, tcdm_req_o, stream_ready_o, cnt_o);
      end
      step_cycle();
      checks++;
      if (done_o !== 1'b0 || ready_start_o !== 1'b1 || tcdm_req_o !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_after got done=%b rdy=%b req=%b expected 0 1 0",
                  done_o, ready_start_o, tcdm_req_o);
      end
      stream_valid_i = 1'b0;
      tcdm_gnt_i     = 1'b0;
   endtask

   task automatic test_ignored_restart();
      int cyc;
      start_job(mk_job(32'h3000, 6, 0, 32'h0, 4));
      base_addr_i  = 32'h9000;
      trans_size_i = 32'd2;
      req_start_i  = 1'b1;
      drive_job(0, 3, 100, 100, cyc);
      req_start_i  = 1'b0;
      drive_job(3, 3, 100, 100, cyc);
      check_done("restart", 6);
   endtask

   task automatic test_back_to_back();
      int cyc;
      start_job(mk_job(32'h4000, 3, 0, 32'h0, 4));
      drive_job(0, 3, 100, 100, cyc);
      checks++;
      if (done_o !== 1'b1 || cnt_o !== 32'd3) begin
         errors++;
         $display("FAIL b2b_first_done got done=%b cnt=%0d expected 1 3", done_o, cnt_o);
      end
      start_job(mk_job(32'h4100, 5, 2, 32'h20, 4));
      drive_job(0, 5, 100, 100, cyc);
      checks++;
      if (cyc !== 5) begin
         errors++;
         $display("FAIL b2b_cycles got %0d expected 5", cyc);
      end
      check_done("b2b", 5);
   endtask

   task automatic test_abort();
      int cyc;
      start_job(mk_job(32'h6000, 8, 0, 32'h0, 4));
      drive_job(0, 2, 100, 100, cyc);
      clear_i = 1'b1;
      step_cycle();
      clear_i = 1'b0;
      checks++;
      if (ready_start_o !== 1'b1 || done_o !== 1'b0 || cnt_o !== 32'd0 || tcdm_add_o !== 32'd0) begin
         errors++;
         $display("FAIL abort got rdy=%b done=%b cnt=%0d add=%h expected 1 0 0 0",
                  ready_start_o, done_o, cnt_o, tcdm_add_o);
      end
      step_cycle();
      checks++;
      if (done_o !== 1'b0 || ready_start_o !== 1'b1) begin
         errors++;
         $display("FAIL abort_after got done=%b rdy=%b expected 0 1", done_o, ready_start_o);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      start_job(mk_job(32'h7000, 8, 0, 32'h0, 4));
      drive_job(0, 3, 100, 100, cyc);
      stream_valid_i = 1'b1;
      tcdm_gnt_i     = 1'b1;
      rst_ni         = 1'b0;
      #1;
      checks++;
      if (ready_start_o !== 1'b1 || done_o !== 1'b0 || cnt_o !== 32'd0 || stream_ready_o !== 1'b0 ||
          tcdm_req_o !== 1'b0 || tcdm_add_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid got rdy=%b done=%b cnt=%0d srdy=%b req=%b add=%h expected 1 0 0 0 0 0",
                  ready_start_o, done_o, cnt_o, stream_ready_o, tcdm_req_o, tcdm_add_o);
      end
      step_cycle();
      stream_valid_i = 1'b0;
      tcdm_gnt_i     = 1'b0;
      rst_ni         = 1'b1;
      step_cycle();
   endtask

   initial begin
      rst_ni         = 1'b0;
      clear_i        = 1'b0;
      req_start_i    = 1'b0;
      base_addr_i    = '0;
      trans_size_i   = '0;
      line_length_i  = '0;
      line_stride_i  = '0;
      step_i         = '0;
      stream_data_i  = '0;
      stream_strb_i  = '0;
      stream_valid_i = 1'b0;
      tcdm_gnt_i     = 1'b0;

      test_reset();
      test_single_line();
      test_2d();
      test_random();
      test_zero_len();
      test_ignored_restart();
      test_back_to_back();
      test_abort();
      test_reset_mid();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_dataflow_sink_responder.md
Name: multi_dataflow_sink_responder

Overview:
- Responder end of the streamer sink control protocol driven by the HWPE controller FSM.
- Accepts a req_start pulse together with an address-generator job (base, transfer size, line geometry) and reports ready_start when it can take a new job.
- Drains the engine's output stream into TCDM as word writes along a 2-level (word/line) address pattern, then pulses done.
- Sits between the engine outStream port and one TCDM master port, in place of a full hwpe-stream sink.

Parameters:
- ADDR_W, 32, TCDM byte-address width.
- DATA_W, 32, stream/TCDM data width; byte-enable width is DATA_W/8.
- CNT_W, 32, width of trans_size, line_length and the internal counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear: abort job, return to IDLE.
- req_start_i  in  1  job start request from controller FSM.
- base_addr_i  in  ADDR_W  job base byte address.
- trans_size_i  in  CNT_W  total words to write.
- line_length_i  in  CNT_W  words per line; 0 = single line.
- line_stride_i  in  ADDR_W  byte offset between line starts.
- step_i  in  ADDR_W  byte offset between words within a line.
- ready_start_o  out  1  high when IDLE and able to accept req_start.
- done_o  out  1  one-cycle pulse at job completion.
- cnt_o  out  CNT_W  words written so far in the current job.
- stream_data_i  in  DATA_W  incoming engine data.
- stream_strb_i  in  DATA_W/8  incoming byte strobes.
- stream_valid_i  in  1  incoming data valid.
- stream_ready_o  out  1  incoming data accepted.
- tcdm_req_o  out  1  TCDM request.
- tcdm_gnt_i  in  1  TCDM grant.
- tcdm_add_o  out  ADDR_W  TCDM byte address.
- tcdm_wen_o  out  1  write enable, active-low; always 0.
- tcdm_be_o  out  DATA_W/8  byte enables (= stream_strb_i).
- tcdm_data_o  out  DATA_W  write data (= stream_data_i).

Behaviour:
- Reset values: state IDLE, all counters 0, latched job registers 0. Outputs: ready_start_o=1, done_o=0, cnt_o=0, stream_ready_o=0, tcdm_req_o=0, tcdm_add_o=0.
- States: IDLE, RUN.
- IDLE:
  - ready_start_o=1.
  - On req_start_i, latch all job inputs, clear counters, and set line_base=addr=base_addr_i.
  - If trans_size_i!=0, go to RUN next cycle.
  - If trans_size_i==0, stay in IDLE and pulse done_o next cycle.
- RUN:
  - ready_start_o=0.
  - Combinational pass-through: tcdm_req_o=stream_valid_i, stream_ready_o=tcdm_gnt_i; data and be are passed through.
  - A beat is transferred when stream_valid_i & tcdm_gnt_i.
  - The first request can be issued in the first RUN cycle; a new beat can be transferred every cycle.
- Address generation per beat:
  - If word_cnt == line_len-1: line_base += line_stride, addr = line_base + line_stride, word_cnt = 0.
  - Otherwise: addr += step, word_cnt += 1.
  - line_len = latched line_length, or latched trans_size if line_length is 0.
  - All address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Completion: on the beat where cnt reaches trans_size (cnt_o == trans_size-1 at the beat), go to IDLE next cycle. In that cycle done_o=1 and ready_start_o=1.
- req_start_i while in RUN is ignored; no latch and no error.
- req_start_i coinciding with the done_o cycle (IDLE) is accepted normally.
- Input changes after the latch do not affect the running job.
- Back-pressure:
  - stream_valid_i=1 & tcdm_gnt_i=0: hold; address and counters unchanged.
  - stream_valid_i=0: tcdm_req_o=0.
  - tcdm_gnt_i without a request is ignored.
- clear_i has priority over everything: next cycle IDLE with counters zeroed and done_o=0. A transfer in the clear cycle still completes on the bus but is not counted.
- Reset mid-job: immediate return to reset values; no done_o.
- cnt_o increments on each beat and holds its final value in IDLE until the next accepted req_start.

Decomposition:
- Shared package multi_dataflow_package:
  - state enum sink_resp_state_t.
  - struct sink_resp_job_t (base_addr, trans_size, line_length, line_stride, step).
  - localparams for default widths.
- One sub-module, multi_dataflow_sink_addrgen: holds the job registers, word/line counters and address. Inputs: load, advance, clear. Outputs: addr, cnt, last.
- The top level keeps the FSM and the TCDM/stream glue.

Test Plan:
- Single line, no stall: base=0x1000, trans=4, line_len=0, step=4, valid and gnt always 1. Required: addresses 0x1000/04/08/0C on 4 consecutive cycles; done_o one cycle after the 4th beat; ready_start_o low for exactly 4 cycles.
- 2D pattern: base=0x2000, trans=6, line_len=3, step=4, stride=0x40. Required: addresses 0x2000,2004,2008,2040,2044,2048; cnt_o=6 at done.
- Random back-pressure: gnt 50%, valid 70%, trans=16. Required: no address skipped or repeated; stream_ready_o==tcdm_gnt_i only in RUN; the scoreboard matches data/be per address.
- Zero length: req_start with trans=0. Required: no tcdm_req_o; done_o pulse next cycle; ready_start_o stays 1.
- Ignored restart: req_start in RUN with different base. Required: job continues at the original addresses.
- Back-to-back: req_start in the done cycle starts a new job with no gap.
- Abort: clear_i after 2 of 8 beats. Required: IDLE next cycle, no done_o, cnt_o=0.
- Reset mid-job: rst_ni low after 3 beats. Required: all outputs at reset values asynchronously.
